// File: rtl/video_start_sequencer_pkg.sv
// rtl/video_start_sequencer_pkg.sv - state encoding, default timing and helpers for the video start sequencer
package video_start_sequencer_pkg;

    localparam logic [1:0] ST_HOLD       = 2'd0;
    localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
    localparam logic [1:0] ST_FILL       = 2'd2;
    localparam logic [1:0] ST_RUN        = 2'd3;

    localparam int DEF_FILL_LINES    = 2;
    localparam int DEF_HOLD_CYCLES   = 16;
    localparam int DEF_LINE_TIMEOUT  = 4096;
    localparam int DEF_FRAME_TIMEOUT = 2000000;

    // One counter serves as hold timer, line timeout and frame watchdog
    localparam int CNT_W = 21;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/video_start_sequencer_cfg_sync.sv
// rtl/video_start_sequencer_cfg_sync.sv - two-flop synchronizer for one asynchronous mode request bit
module video_start_sequencer_cfg_sync (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/video_start_sequencer.sv
// rtl/video_start_sequencer.sv - holds the RAM-to-video stage in reset, fills lines, triggers start, watchdogs both sides
module video_start_sequencer
    import video_start_sequencer_pkg::*;
#(
    parameter int FILL_LINES    = DEF_FILL_LINES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int LINE_TIMEOUT  = DEF_LINE_TIMEOUT,
    parameter int FRAME_TIMEOUT = DEF_FRAME_TIMEOUT
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_line_doubler_req,
    input  logic       i_add_line_req,
    input  logic       i_frame_start,
    input  logic       i_line_done,
    output logic       o_video_reset_n,
    output logic       o_starttrigger,
    output logic       o_line_doubler,
    output logic       o_add_line,
    output logic       o_running,
    output logic [7:0] o_resync_count
);

    localparam int LINE_W = $clog2(FILL_LINES + 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [LINE_W-1:0] r_lines;
    logic              r_pend;
    logic              r_vrst_n;
    logic              r_start;
    logic              r_ld;
    logic              r_al;
    logic              r_run;
    logic [7:0]        r_resync;

    logic              w_ld_s;
    logic              w_al_s;
    logic              w_mode_diff;
    logic [LINE_W-1:0] w_lines_inc;

    video_start_sequencer_cfg_sync u_sync_ld (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_async   (i_line_doubler_req),
        .o_sync    (w_ld_s)
    );

    video_start_sequencer_cfg_sync u_sync_al (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_async   (i_add_line_req),
        .o_sync    (w_al_s)
    );

    assign w_mode_diff = (w_ld_s != r_ld) || (w_al_s != r_al);
    assign w_lines_inc = r_lines + LINE_W'(1);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= ST_HOLD;
            r_cnt    <= '0;
            r_lines  <= '0;
            r_pend   <= 1'b0;
            r_vrst_n <= 1'b0;
            r_start  <= 1'b0;
            r_ld     <= 1'b0;
            r_al     <= 1'b0;
            r_run    <= 1'b0;
            r_resync <= 8'd0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_HOLD: begin
                    r_vrst_n <= 1'b0;
                    r_run    <= 1'b0;
                    // Mode bits may only move while the output stage is held in reset
                    if (r_cnt == '0) begin
                        r_ld <= w_ld_s;
                        r_al <= w_al_s;
                    end
                    if (r_cnt >= CNT_W'(HOLD_CYCLES - 1)) begin
                        r_vrst_n <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_WAIT_FRAME;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_WAIT_FRAME: begin
                    if (w_mode_diff) begin
                        r_state  <= ST_HOLD;
                        r_cnt    <= '0;
                        r_vrst_n <= 1'b0;
                    end else if (i_frame_start) begin
                        r_lines <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_FILL;
                    end
                end

                ST_FILL: begin
                    r_cnt <= i_line_done ? '0 : r_cnt + CNT_W'(1);
                    if (!i_line_done && r_cnt >= CNT_W'(LINE_TIMEOUT - 1)) begin
                        r_state  <= ST_HOLD;
                        r_cnt    <= '0;
                        r_vrst_n <= 1'b0;
                        r_resync <= sat_inc8(r_resync);
                    end else if (i_frame_start) begin
                        r_lines <= '0;
                    end else if (i_line_done) begin
                        if (w_lines_inc == LINE_W'(FILL_LINES)) begin
                            r_start <= 1'b1;
                            r_run   <= 1'b1;
                            r_pend  <= 1'b0;
                            r_state <= ST_RUN;
                        end else begin
                            r_lines <= w_lines_inc;
                        end
                    end
                end

                ST_RUN: begin
                    r_run  <= 1'b1;
                    r_pend <= w_mode_diff;
                    if (i_frame_start) begin
                        r_cnt <= '0;
                        // A pending mode change is applied at the frame boundary, not counted as a resync
                        if (r_pend) begin
                            r_state  <= ST_HOLD;
                            r_vrst_n <= 1'b0;
                            r_run    <= 1'b0;
                            r_pend   <= 1'b0;
                        end
                    end else if (r_cnt >= CNT_W'(FRAME_TIMEOUT - 1)) begin
                        r_state  <= ST_HOLD;
                        r_cnt    <= '0;
                        r_vrst_n <= 1'b0;
                        r_run    <= 1'b0;
                        r_pend   <= 1'b0;
                        r_resync <= sat_inc8(r_resync);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_state  <= ST_HOLD;
                    r_cnt    <= '0;
                    r_vrst_n <= 1'b0;
                    r_run    <= 1'b0;
                end
            endcase
        end
    end

    assign o_video_reset_n = r_vrst_n;
    assign o_starttrigger  = r_start;
    assign o_line_doubler  = r_ld;
    assign o_add_line      = r_al;
    assign o_running       = r_run;
    assign o_resync_count  = r_resync;

endmodule

// File: tb/tb_video_start_sequencer.sv
// tb/tb_video_start_sequencer.sv - table-driven and hand-sequenced checks of video_start_sequencer
module tb_video_start_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ldr;
    logic       alr;
    logic       fs;
    logic       ldn;
    logic       vrst;
    logic       start;
    logic       ld;
    logic       al;
    logic       run;
    logic [7:0] rc;

    int n_vec;
    int n_err;
    bit saw_start;

    typedef struct {
        int   reps;
        logic fs, ldn, ldr, alr;
        logic vrst, start, run, ld, al;
    } vec_t;

    vec_t tbl[$];

    video_start_sequencer #(
        .FILL_LINES    (2),
        .HOLD_CYCLES   (4),
        .LINE_TIMEOUT  (100),
        .FRAME_TIMEOUT (1000)
    ) dut (
        .i_clock            (clk),
        .i_reset_n          (rst_n),
        .i_line_doubler_req (ldr),
        .i_add_line_req     (alr),
        .i_frame_start      (fs),
        .i_line_done        (ldn),
        .o_video_reset_n    (vrst),
        .o_starttrigger     (start),
        .o_line_doubler     (ld),
        .o_add_line         (al),
        .o_running          (run),
        .o_resync_count     (rc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    function automatic logic [12:0] obs();
        return {vrst, start, run, ld, al, rc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (start === 1'b1) saw_start = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int reps, input logic a_fs, input logic a_ldn, input logic a_ldr,
                       input logic a_alr, input logic e_vrst, input logic e_start, input logic e_run,
                       input logic e_ld, input logic e_al);
        vec_t v;
        v.reps = reps; v.fs = a_fs; v.ldn = a_ldn; v.ldr = a_ldr; v.alr = a_alr;
        v.vrst = e_vrst; v.start = e_start; v.run = e_run; v.ld = e_ld; v.al = e_al;
        tbl.push_back(v);
    endtask

    task automatic wait_vrst(input logic val, input int bound, output int n);
        n = 0;
        while (vrst !== val && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_fs();
        fs = 1'b1;
        tick();
        fs = 1'b0;
    endtask

    initial begin
        int n;
        int exp_rc;
        n_vec = 0;
        n_err = 0;
        saw_start = 1'b0;
        rst_n = 1'b0;
        ldr = 1'b0; alr = 1'b0; fs = 1'b0; ldn = 1'b0;

        // Edge numbering: edge 0 is the first rising edge after reset release
        //  reps fs ld ldr alr | vrst start run ld al
        add(3,  0,0,0,0,  0,0,0,0,0);   // 0-2 hold
        add(7,  0,0,0,0,  1,0,0,0,0);   // 3-9 wait frame
        add(1,  1,0,0,0,  1,0,0,0,0);   // 10 frame start
        add(9,  0,0,0,0,  1,0,0,0,0);
        add(1,  0,1,0,0,  1,0,0,0,0);   // 20 first line
        add(9,  0,0,0,0,  1,0,0,0,0);
        add(1,  0,1,0,0,  1,1,1,0,0);   // 30 second line -> trigger
        add(10, 0,0,0,0,  1,0,1,0,0);
        add(50, 0,0,0,1,  1,0,1,0,0);   // 41-90 add_line request pending
        add(1,  1,0,0,1,  0,0,0,0,0);   // 91 frame start applies it
        add(3,  0,0,0,1,  0,0,0,0,1);   // 92-94 hold with new mode
        add(5,  0,0,0,1,  1,0,0,0,1);   // 95-99 wait frame
        add(1,  1,1,0,1,  1,0,0,0,1);   // 100 frame start, line_done ignored
        add(4,  0,0,0,1,  1,0,0,0,1);
        add(1,  0,1,0,1,  1,0,0,0,1);   // 105 line 1
        add(4,  0,0,0,1,  1,0,0,0,1);
        add(1,  1,1,0,1,  1,0,0,0,1);   // 110 restart, line not counted
        add(4,  0,0,0,1,  1,0,0,0,1);
        add(1,  0,1,0,1,  1,0,0,0,1);   // 115 line 1 again, no trigger
        add(4,  0,0,0,1,  1,0,0,0,1);
        add(1,  0,1,0,1,  1,1,1,0,1);   // 120 line 2 -> trigger
        add(5,  0,0,0,1,  1,0,1,0,1);
        add(5,  0,0,1,1,  1,0,1,0,1);   // 126-130 line_doubler requested
        add(9,  0,0,0,1,  1,0,1,0,1);   // reverted
        add(1,  1,0,0,1,  1,0,1,0,1);   // 140 frame start, nothing pending
        add(5,  0,0,0,1,  1,0,1,0,1);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 32'(obs()), 32'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            fs = tbl[i].fs; ldn = tbl[i].ldn; ldr = tbl[i].ldr; alr = tbl[i].alr;
            for (int r = 0; r < tbl[i].reps; r++) begin
                tick();
                chk($sformatf("vec%0d_rep%0d", i, r), 32'(obs()),
                    32'({tbl[i].vrst, tbl[i].start, tbl[i].run, tbl[i].ld, tbl[i].al, 8'd0}));
            end
        end
        fs = 1'b0; ldn = 1'b0; ldr = 1'b0;

        // Frame watchdog in RUN
        pulse_fs();
        saw_start = 1'b0;
        wait_vrst(1'b0, 1100, n);
        chk("frame_timeout_cycles", 32'(n), 32'd1000);
        chk("frame_timeout_resync", 32'(rc), 32'd1);
        chk("frame_timeout_run", 32'(run), 32'd0);
        chk("frame_timeout_no_start", 32'(saw_start), 32'd0);
        wait_vrst(1'b1, 20, n);
        chk("hold_len_after_frame_to", 32'(n), 32'd4);

        // Line timeout in FILL
        pulse_fs();
        wait_vrst(1'b0, 200, n);
        chk("line_timeout_cycles", 32'(n), 32'd100);
        chk("line_timeout_resync", 32'(rc), 32'd2);
        wait_vrst(1'b1, 20, n);
        chk("hold_len_after_line_to", 32'(n), 32'd4);

        // Saturate resync_count through repeated line timeouts
        exp_rc = 2;
        for (int i = 0; i < 260; i++) begin
            pulse_fs();
            wait_vrst(1'b0, 200, n);
            wait_vrst(1'b1, 20, n);
            exp_rc = (exp_rc >= 255) ? 255 : exp_rc + 1;
            chk($sformatf("resync_sat_%0d", i), 32'(rc), 32'(exp_rc));
        end

        // Asynchronous reset mid-FILL
        pulse_fs();
        repeat (3) tick();
        ldn = 1'b1;
        tick();
        ldn = 1'b0;
        tick();
        chk("pre_async_vrst", 32'(vrst), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(obs()), 32'd0);
        rst_n = 1'b1;
        wait_vrst(1'b1, 20, n);
        chk("hold_len_after_reset", 32'(n), 32'd4);
        chk("resync_after_reset", 32'(rc), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/video_start_sequencer.md
Name: video_start_sequencer

Overview:
- Sequences the RAM-to-video output stage: holds it in reset, waits for the capture side to start a frame, and pulses starttrigger once FILL_LINES lines are buffered.
- Owns the line_doubler/add_line mode bits fed to the output stage and changes them only while that stage is held in reset, at an input frame boundary.
- Watchdogs both sides and forces a full resync on loss of input.
- Sits between the capture/write side, the config register interface and the output timing generator.

Parameters:
- FILL_LINES, 2: input lines that must complete after frame start before starttrigger.
- HOLD_CYCLES, 16: cycles video_reset_n is held low per resync (≥4).
- LINE_TIMEOUT, 4096: max cycles between line_done pulses while filling.
- FRAME_TIMEOUT, 2000000: max cycles between frame_start pulses while running.

Ports:
- clock  in  1  output pixel clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- line_doubler_req  in  1  requested mode bit; asynchronous; 2-flop synchronized internally.
- add_line_req  in  1  requested mode bit; asynchronous; 2-flop synchronized internally.
- frame_start  in  1  single-cycle pulse, synchronous to clock: first input line of a frame is being written.
- line_done  in  1  single-cycle pulse, synchronous to clock: one input line fully written to RAM.
- video_reset_n  out  1  active-low reset to the output stage.
- starttrigger  out  1  single-cycle start pulse to the output stage.
- line_doubler  out  1  applied mode bit.
- add_line  out  1  applied mode bit.
- running  out  1  high while in RUN.
- resync_count  out  8  saturating count of watchdog-induced resyncs.

Behaviour:
- Reset values: state HOLD, hold counter 0, video_reset_n=0, starttrigger=0, line_doubler=0, add_line=0, running=0, resync_count=0, synchronizer flops 0.
- All outputs are registered. Synchronized requests are called ld_s and al_s.
- HOLD:
  - video_reset_n=0.
  - line_doubler<=ld_s and add_line<=al_s on the first HOLD cycle only.
  - After HOLD_CYCLES cycles: video_reset_n<=1, go to WAIT_FRAME.
- WAIT_FRAME:
  - On frame_start: line counter<=0, go to FILL.
  - line_done is ignored in this state, including in the same cycle as frame_start.
  - A change in ld_s/al_s vs the applied bits: go to HOLD with no frame wait, since output is not yet running.
- FILL:
  - line_done increments the line counter and clears the timeout counter.
  - When the counter reaches FILL_LINES: starttrigger=1 for exactly one cycle, go to RUN.
  - frame_start during FILL (with or without line_done): counter<=0 and stay in FILL; that line_done is not counted.
  - Timeout counter reaches LINE_TIMEOUT: go to HOLD, resync_count++.
- RUN:
  - running=1.
  - The frame watchdog clears on frame_start; when it reaches FRAME_TIMEOUT: go to HOLD, resync_count++.
  - Mode change pending (ld_s/al_s differ from the applied bits): latch a pending flag. On the next frame_start, go to HOLD; resync_count is unchanged.
  - If the mode change is reverted before that frame_start, clear the pending flag and stay in RUN.
- Leaving any state for HOLD: video_reset_n<=0 in the same clock edge, and the hold counter clears.
- resync_count saturates at 255.
- starttrigger is never asserted while video_reset_n=0 or outside the FILL→RUN transition.
- Counter widths: line counter clog2(FILL_LINES+1); timeout/watchdog counter 21 bits, shared, cleared on every state entry.
- Asynchronous reset mid-operation: all state returns to reset values immediately; video_reset_n drops asynchronously.

Decomposition:
- Shared include (alongside config.inc) holds:
  - state encoding localparams: HOLD=0, WAIT_FRAME=1, FILL=2, RUN=3;
  - default values for FILL_LINES, HOLD_CYCLES, LINE_TIMEOUT and FRAME_TIMEOUT.
- One sub-module: cfg_sync, a 2-flop synchronizer with asynchronous active-low reset, instantiated once per mode bit.

Test Plan (HOLD_CYCLES=4, FILL_LINES=2, LINE_TIMEOUT=100, FRAME_TIMEOUT=1000):
- Release reset, frame_start at cycle 10, line_done at 20 and 30 → video_reset_n high at cycle 4; starttrigger one-cycle pulse at cycle 31; running=1 from 31.
- In FILL after 1 line_done, frame_start → counter restarts; starttrigger only after 2 further line_done pulses.
- In FILL, no line_done for 100 cycles → video_reset_n=0 next cycle, resync_count=1, re-enters WAIT_FRAME after 4 cycles.
- In RUN, toggle add_line_req 0→1, frame_start 50 cycles later → add_line=1 exactly during HOLD, video_reset_n low 4 cycles, resync_count unchanged, restart completes.
- In RUN, toggle line_doubler_req 0→1→0 before any frame_start → no HOLD entry, line_doubler stays 0.
- In RUN, no frame_start for 1000 cycles, repeated 300 times → resync_count saturates at 255; async reset asserted mid-FILL → all outputs return to reset values without waiting for a clock edge.
